// File: rtl/div_err_pkg.sv
// -----------------------------------------------------------------------------
// div_err_pkg
// Shared definitions for the divider error accumulator:
//   - state_t     : accumulator FSM states (IDLE, RUN, DRAIN, DONE)
//   - DEF_*       : default quotient / counter / sum widths
//   - sat_add()   : unsigned saturating add, clamped to a run-time width
// -----------------------------------------------------------------------------
package div_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_QW    = 8;
    localparam int DEF_CNT_W = 24;
    localparam int DEF_SUM_W = 32;

    // Widest accumulator the helper supports.
    localparam int SAT_ACC_W = 64;

    typedef struct packed {
        logic                 ovf;
        logic [SAT_ACC_W-1:0] sum;
    } sat_res_t;

    // a + b clamped to 2^w-1; ovf is set whenever the clamp engages.
    // Operands are zero-extended by the caller to SAT_ACC_W bits.
    function automatic sat_res_t sat_add(
        input logic [SAT_ACC_W-1:0] a,
        input logic [SAT_ACC_W-1:0] b,
        input int unsigned          w
    );
        logic [SAT_ACC_W:0] full;
        logic [SAT_ACC_W:0] lim;
        sat_res_t           res;
        full = {1'b0, a} + {1'b0, b};
        if (w >= 32'(SAT_ACC_W)) begin
            lim = {1'b0, {SAT_ACC_W{1'b1}}};
        end else begin
            lim = ((SAT_ACC_W+1)'(1) << w) - (SAT_ACC_W+1)'(1);
        end
        if (full > lim) begin
            res.ovf = 1'b1;
            res.sum = lim[SAT_ACC_W-1:0];
        end else begin
            res.ovf = 1'b0;
            res.sum = full[SAT_ACC_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/div_abs_diff.sv
// -----------------------------------------------------------------------------
// div_abs_diff
// Combinational unsigned magnitude |a - b|, QW bits wide.
// Ports:
//   i_a, i_b : QW-bit unsigned operands
//   o_diff   : QW-bit unsigned |i_a - i_b|
// -----------------------------------------------------------------------------
module div_abs_diff #(
    parameter int QW = 8
) (
    input  logic [QW-1:0] i_a,
    input  logic [QW-1:0] i_b,
    output logic [QW-1:0] o_diff
);

    // Subtract the smaller operand from the larger so the result never wraps.
    always_comb begin
        if (i_a >= i_b) begin
            o_diff = i_a - i_b;
        end else begin
            o_diff = i_b - i_a;
        end
    end

endmodule

// File: rtl/div_err_accumulator.sv
// -----------------------------------------------------------------------------
// div_err_accumulator
// Collects error statistics between an approximate and an exact divider over a
// programmed number of samples: saturating sum of |q_apx-q_exa|, maximum
// error, count of erroneous samples and count of skipped zero-divisor samples.
//
// Optional feature macro: DIV_ERR_REM_EN
//   When defined, remainder inputs r_apx/r_exa are added and the remainder
//   error sum/max (rem_err_sum, rem_err_max) are accumulated with the same
//   skip rules. Saturation of either sum sets the shared sticky sat flag.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, num_samples  : begin a run of num_samples samples (IDLE/DONE only)
//   in_valid, in_ready  : sample handshake
//   d, q_apx, q_exa     : divisor and the two quotients of a sample
//   busy, done          : run status (RUN|DRAIN, DONE)
//   err_sum, err_max    : saturating error sum, maximum error
//   err_cnt, skip_cnt   : erroneous-sample count, zero-divisor sample count
//   sat                 : sticky, an error sum saturated
// -----------------------------------------------------------------------------
module div_err_accumulator
    import div_err_pkg::*;
#(
    parameter int QW    = DEF_QW,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [QW-1:0]    d,
    input  logic [QW-1:0]    q_apx,
    input  logic [QW-1:0]    q_exa,
`ifdef DIV_ERR_REM_EN
    input  logic [QW-1:0]    r_apx,
    input  logic [QW-1:0]    r_exa,
    output logic [SUM_W-1:0] rem_err_sum,
    output logic [QW-1:0]    rem_err_max,
`endif
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] err_sum,
    output logic [QW-1:0]    err_max,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_clear;
    logic             w_hs;
    logic [CNT_W-1:0] w_cnt_inc;

    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_acc_cnt;

    logic             r_s1_valid;
    logic             r_s1_skip;
    logic [QW-1:0]    r_s1_e;
    logic [QW-1:0]    w_q_diff;

    logic [SUM_W-1:0] r_err_sum;
    logic [QW-1:0]    r_err_max;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_skip_cnt;
    logic             r_sat;
    sat_res_t         w_sum_res;
    logic             w_rem_ovf;

    div_abs_diff #(.QW(QW)) u_q_diff (
        .i_a    (q_apx),
        .i_b    (q_exa),
        .o_diff (w_q_diff)
    );

`ifdef DIV_ERR_REM_EN
    logic [QW-1:0]    w_r_diff;
    logic [QW-1:0]    r_s1_re;
    logic [SUM_W-1:0] r_rem_err_sum;
    logic [QW-1:0]    r_rem_err_max;
    sat_res_t         w_rem_res;

    div_abs_diff #(.QW(QW)) u_r_diff (
        .i_a    (r_apx),
        .i_b    (r_exa),
        .o_diff (w_r_diff)
    );

    // Remainder error sum with the same clamp as the quotient sum.
    always_comb begin
        w_rem_res = sat_add(SAT_ACC_W'(r_rem_err_sum), SAT_ACC_W'(r_s1_re),
                            32'(SUM_W));
        w_rem_ovf = w_rem_res.ovf;
    end

    // Remainder S1 capture and S2 statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_re       <= '0;
            r_rem_err_sum <= '0;
            r_rem_err_max <= '0;
        end else begin
            if (w_hs) begin
                r_s1_re <= w_r_diff;
            end else begin
                r_s1_re <= r_s1_re;
            end
            if (w_clear) begin
                r_rem_err_sum <= '0;
                r_rem_err_max <= '0;
            end else if (r_s1_valid && !r_s1_skip) begin
                r_rem_err_sum <= w_rem_res.sum[SUM_W-1:0];
                if (r_s1_re > r_rem_err_max) begin
                    r_rem_err_max <= r_s1_re;
                end else begin
                    r_rem_err_max <= r_rem_err_max;
                end
            end else begin
                r_rem_err_sum <= r_rem_err_sum;
                r_rem_err_max <= r_rem_err_max;
            end
        end
    end

    assign rem_err_sum = r_rem_err_sum;
    assign rem_err_max = r_rem_err_max;
`else
    assign w_rem_ovf = 1'b0;
`endif

    assign w_hs      = in_valid && (r_state == RUN);
    assign w_cnt_inc = r_acc_cnt + CNT_ONE;

    // Next-state logic; w_clear marks an accepted start.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_clear = 1'b1;
                    if (num_samples == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            RUN: begin
                if (w_hs && (w_cnt_inc == r_target)) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                // S1 empty means the last sample has reached the statistics.
                if (!r_s1_valid) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register plus registered status outputs decoded from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == RUN);
            r_busy     <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
            r_done     <= (w_state_nxt == DONE);
        end
    end

    // Target capture and handshake counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target  <= '0;
            r_acc_cnt <= '0;
        end else if (w_clear) begin
            r_target  <= num_samples;
            r_acc_cnt <= '0;
        end else if (w_hs) begin
            r_target  <= r_target;
            r_acc_cnt <= w_cnt_inc;
        end else begin
            r_target  <= r_target;
            r_acc_cnt <= r_acc_cnt;
        end
    end

    // Pipeline stage 1: error magnitude and skip flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_skip  <= 1'b0;
            r_s1_e     <= '0;
        end else if (w_hs) begin
            r_s1_valid <= 1'b1;
            r_s1_skip  <= (d == '0);
            r_s1_e     <= w_q_diff;
        end else begin
            r_s1_valid <= 1'b0;
            r_s1_skip  <= r_s1_skip;
            r_s1_e     <= r_s1_e;
        end
    end

    // Saturating quotient error sum for the sample in S1.
    always_comb begin
        w_sum_res = sat_add(SAT_ACC_W'(r_err_sum), SAT_ACC_W'(r_s1_e), 32'(SUM_W));
    end

    // Pipeline stage 2: statistics update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sum  <= '0;
            r_err_max  <= '0;
            r_err_cnt  <= '0;
            r_skip_cnt <= '0;
            r_sat      <= 1'b0;
        end else if (w_clear) begin
            r_err_sum  <= '0;
            r_err_max  <= '0;
            r_err_cnt  <= '0;
            r_skip_cnt <= '0;
            r_sat      <= 1'b0;
        end else if (r_s1_valid && r_s1_skip) begin
            r_skip_cnt <= r_skip_cnt + CNT_ONE;
        end else if (r_s1_valid) begin
            r_err_sum <= w_sum_res.sum[SUM_W-1:0];
            r_sat     <= r_sat || w_sum_res.ovf || w_rem_ovf;
            if (r_s1_e > r_err_max) begin
                r_err_max <= r_s1_e;
            end else begin
                r_err_max <= r_err_max;
            end
            if (r_s1_e != '0) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end else begin
                r_err_cnt <= r_err_cnt;
            end
        end else begin
            r_err_sum  <= r_err_sum;
            r_err_max  <= r_err_max;
            r_err_cnt  <= r_err_cnt;
            r_skip_cnt <= r_skip_cnt;
            r_sat      <= r_sat;
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err_sum  = r_err_sum;
    assign err_max  = r_err_max;
    assign err_cnt  = r_err_cnt;
    assign skip_cnt = r_skip_cnt;
    assign sat      = r_sat;

endmodule

// File: doc/div_err_accumulator.md
Name: div_err_accumulator

Overview:
- Sits directly downstream of an approximate 16/8 array divider and its exact counterpart; both are driven with the same n/d.
- Consumes each (approx, exact) quotient pair per sample and accumulates error statistics over a programmed number of samples.
- Accumulated figures: sum of absolute quotient error (MAE numerator), maximum error, and count of erroneous samples.
- Results feed the MAE characterisation flow and are read by the host once done is asserted.

Parameters:
- QW, 8, quotient/remainder width; matches the divider q/r width.
- CNT_W, 24, width of the sample target and all counters.
- SUM_W, 32, width of the error-sum accumulator.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- num_samples  in  CNT_W  target sample count; sampled on start
- in_valid  in  1  sample present on q_apx/q_exa/d
- in_ready  out  1  block accepts a sample this cycle
- d  in  QW  divisor of the sample; zero-divisor samples are skipped
- q_apx  in  QW  approximate divider quotient
- q_exa  in  QW  exact divider quotient
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE until the next start
- err_sum  out  SUM_W  saturating sum of |q_apx-q_exa|
- err_max  out  QW  maximum |q_apx-q_exa| seen
- err_cnt  out  CNT_W  samples with nonzero error
- skip_cnt  out  CNT_W  zero-divisor samples consumed
- sat  out  1  sticky; err_sum saturated

Behaviour:
- Reset:
  - All outputs are 0; FSM is in IDLE.
  - Any transaction in flight is discarded; no partial result survives reset.
- States:
  - IDLE: start loads the target and clears all statistics, skip_cnt and sat, then goes to RUN.
  - RUN: in_ready=1.
    - A handshake is a cycle with in_valid&in_ready.
    - The accepted-sample counter counts every handshake, skipped samples included.
    - When the handshake that makes the counter equal the target occurs, go to DRAIN next cycle. in_ready is 0 from that cycle on.
  - DRAIN: in_ready=0; wait until both pipeline stages are empty (2 cycles), then go to DONE.
  - DONE: done=1; statistics are held. start clears them and reenters RUN.
- num_samples=0 on start: go straight to DONE next cycle with all statistics 0.
- start outside IDLE/DONE: ignored.
- Pipeline, latency 2 cycles from handshake to statistics update:
  - S1 registers e = |q_apx - q_exa|, computed as an unsigned QW-bit magnitude, plus a skip flag (d==0).
  - S2 updates the statistics:
    - skip: skip_cnt+1 only.
    - else: err_sum += e, err_max = max(err_max, e), err_cnt+1 if e!=0.
- Saturation:
  - err_sum clamps at 2^SUM_W-1 and sets sat.
  - Counters cannot overflow: the target is limited to CNT_W bits.
- Start in DONE in the same cycle as a stale in_valid: start wins; the sample is not accepted (in_ready=0 in DONE).

Optional Feature:
- Macro: DIV_ERR_REM_EN.
- With the macro defined:
  - Extra inputs r_apx and r_exa (QW each).
  - Extra outputs rem_err_sum (SUM_W, saturating; saturation also sets sat) and rem_err_max (QW).
  - Both are accumulated in S2 with the same skip rules.
- Without the macro: these ports and registers do not exist.

Decomposition:
- Package div_err_pkg: FSM state enum (IDLE, RUN, DRAIN, DONE), default QW/CNT_W/SUM_W localparams, saturating-add function.
- One sub-module, div_abs_diff: combinational unsigned |a-b|, QW wide. It is instantiated once for q, and once more for r under DIV_ERR_REM_EN.

Test Plan:
- Reset mid-RUN after 3 handshakes -> all outputs 0, state IDLE, in_ready=0 next cycle.
- start, num_samples=4; pairs (q_apx,q_exa)=(5,5),(7,4),(2,9),(0,0), d=3 -> done; err_sum=10, err_max=7, err_cnt=2, skip_cnt=0.
- num_samples=3 with d=0,5,0 and q_apx=q_exa+1 -> skip_cnt=2, err_cnt=1, err_sum=1.
- num_samples=0 -> done one cycle after start; all statistics 0.
- SUM_W=8 build, 3 samples with error 255 -> err_sum=255, sat=1.
- Back-to-back start from DONE, then in_valid held high continuously -> exactly num_samples handshakes accepted; in_ready drops in the cycle after the last handshake.
